repairmb_initiator: RTL and testbench
=====================================

Name: repairmb_initiator

Overview:
- Initiator side of the MBINIT.REPAIRMB sideband handshake, the counterpart of the REPAIRMB partner responder.
- Sequence: start_req, then apply_degrade_req carrying the local functional-lane result in msginfo, then end_req.
- Resends apply_degrade_req once when the partner side signals a repeat.
- Reports the final TX lane map, done or train error to the MBINIT controller.

Parameters:
- TIMEOUT_CYCLES, 8000: cycles allowed from leaving IDLE to reaching DONE; exceeding it is a train error.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_MBINIT_REVERSALMB_end  in  1  level enable; low forces IDLE
- i_Busy_SideBand  in  1  sideband TX busy
- i_falling_edge_busy  in  1  one-cycle pulse: sideband finished the current message
- i_RX_SbMessage  in  4  decoded received message
- i_msg_valid  in  1  i_RX_SbMessage valid this cycle
- i_lane_status  in  2  local lane result: 11 = all lanes, 01 = lower half, 10 = upper half, 00 = none
- i_Start_Repeater  in  1  pulse from partner logic: resend apply_degrade_req
- o_TX_SbMessage  out  4  message to sideband TX
- o_ValidOutData  out  1  one-cycle send strobe
- o_tx_msginfo  out  2  lane code sent with apply_degrade_req; 00 otherwise
- o_Done_Repeater  out  1  one-cycle pulse: repeated request sent
- o_Functional_Lanes  out  2  committed TX lane map
- o_train_error  out  1  level, held while enabled
- o_MBINIT_REPAIRMB_end  out  1  level, held in DONE

Behaviour:
- Reset values: o_TX_SbMessage=0000, o_ValidOutData=0, o_tx_msginfo=00, o_Done_Repeater=0, o_Functional_Lanes=11, o_train_error=0, o_MBINIT_REPAIRMB_end=0. Internal state: state=IDLE, timeout counter=0, repeat flag=0.
- Message codes: start_req 0001, start_resp 0010, end_req 0011, end_resp 0100, apply_degrade_req 0101, apply_degrade_resp 0110.
- Outputs are registered and decoded from the next state. On entry to a SEND_* state, o_ValidOutData=1 and o_TX_SbMessage=code for exactly one cycle; both are 0 otherwise.
- State transitions:
  - IDLE -> WAIT_BUSY_START when enable=1.
  - WAIT_BUSY_START -> SEND_START_REQ when busy=0.
  - SEND_START_REQ -> WAIT_START_RESP on falling_edge_busy.
  - WAIT_START_RESP -> DEGRADE_CHECK on msg_valid with start_resp.
  - DEGRADE_CHECK (1 cycle, samples i_lane_status into lanes_q) -> TRAIN_ERROR if status=00; else -> WAIT_BUSY_DEGRADE.
  - WAIT_BUSY_DEGRADE -> SEND_DEGRADE_REQ when busy=0. While sending, o_tx_msginfo=lanes_q.
  - SEND_DEGRADE_REQ -> WAIT_DEGRADE_RESP on falling_edge_busy. If the repeat flag is set, pulse o_Done_Repeater for 1 cycle.
  - WAIT_DEGRADE_RESP:
    - msg_valid with apply_degrade_resp -> o_Functional_Lanes<=lanes_q, then -> WAIT_BUSY_END.
    - i_Start_Repeater with repeat flag=0 -> set flag, -> DEGRADE_CHECK (re-sample).
    - i_Start_Repeater with flag=1 -> TRAIN_ERROR.
    - If apply_degrade_resp and i_Start_Repeater arrive in the same cycle, the resp wins.
  - WAIT_BUSY_END -> SEND_END_REQ when busy=0.
  - SEND_END_REQ -> WAIT_END_RESP on falling_edge_busy.
  - WAIT_END_RESP -> DONE on msg_valid with end_resp.
  - DONE: o_MBINIT_REPAIRMB_end=1, held.
  - TRAIN_ERROR: o_train_error=1, held.
- Ignore rules: messages other than the awaited one, and any message with msg_valid=0, are ignored. i_Start_Repeater outside WAIT_DEGRADE_RESP is ignored.
- Timeout: the counter clears in IDLE and increments every cycle in all other states except DONE and TRAIN_ERROR. When count==TIMEOUT_CYCLES-1 -> TRAIN_ERROR.
- Enable low in any state: state -> IDLE next cycle. All outputs return to reset values except o_Functional_Lanes, which is retained. The repeat flag and counter clear.
- Enable high in DONE or TRAIN_ERROR: the state holds.
- Reset mid-operation: everything returns to reset values asynchronously.

Test Plan:
- Nominal: enable=1, busy=0, lane_status=11, partner answers each request 3 cycles after falling_edge_busy -> sends 0001, 0101 with msginfo=11, 0011; o_Functional_Lanes=11; o_MBINIT_REPAIRMB_end=1 and held.
- Degrade: lane_status=01 -> apply_degrade_req with msginfo=01; after 0110, o_Functional_Lanes=01; flow reaches DONE.
- Repeat: i_Start_Repeater in WAIT_DEGRADE_RESP, lane_status changed to 10 -> second 0101 with msginfo=10, o_Done_Repeater pulses 1 cycle at its falling_edge_busy; a second i_Start_Repeater -> o_train_error=1.
- No lanes: lane_status=00 at DEGRADE_CHECK -> no 0101 sent, o_train_error=1. Partner silent after 0001 -> o_train_error=1 exactly TIMEOUT_CYCLES cycles after leaving IDLE.
- Busy/enable: busy=1 held 10 cycles before start_req -> o_ValidOutData stays 0 until busy=0. Drop enable during WAIT_END_RESP -> IDLE next cycle, outputs cleared, o_Functional_Lanes retained. Re-enable -> fresh start_req.

Source files
------------

// File: rtl/repairmb_initiator.sv
// Initiator side of the MBINIT.REPAIRMB sideband handshake: start_req, apply_degrade_req
// (carrying the local lane result), end_req, with one permitted resend of the degrade request.
module repairmb_initiator #(
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CNT_W          = 13
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_MBINIT_REVERSALMB_end,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    input  logic [3:0] i_RX_SbMessage,
    input  logic       i_msg_valid,
    input  logic [1:0] i_lane_status,
    input  logic       i_Start_Repeater,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutData,
    output logic [1:0] o_tx_msginfo,
    output logic       o_Done_Repeater,
    output logic [1:0] o_Functional_Lanes,
    output logic       o_train_error,
    output logic       o_MBINIT_REPAIRMB_end
);

    localparam logic [3:0] MSG_START_REQ  = 4'b0001;
    localparam logic [3:0] MSG_START_RESP = 4'b0010;
    localparam logic [3:0] MSG_END_REQ    = 4'b0011;
    localparam logic [3:0] MSG_END_RESP   = 4'b0100;
    localparam logic [3:0] MSG_DEG_REQ    = 4'b0101;
    localparam logic [3:0] MSG_DEG_RESP   = 4'b0110;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_BUSY_START,
        SEND_START_REQ,
        WAIT_START_RESP,
        DEGRADE_CHECK,
        WAIT_BUSY_DEGRADE,
        SEND_DEGRADE_REQ,
        WAIT_DEGRADE_RESP,
        WAIT_BUSY_END,
        SEND_END_REQ,
        WAIT_END_RESP,
        DONE,
        TRAIN_ERROR
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             repeat_reg, repeat_next;
    logic [1:0]       lanes_q;
    logic [1:0]       func_lanes_next;
    logic             done_rep_next;
    logic             counting;
    logic             timeout_hit;
    logic             enable;

    function automatic logic [3:0] send_code(input state_t s);
        case (s)
            SEND_START_REQ:   send_code = MSG_START_REQ;
            SEND_DEGRADE_REQ: send_code = MSG_DEG_REQ;
            SEND_END_REQ:     send_code = MSG_END_REQ;
            default:          send_code = 4'b0000;
        endcase
    endfunction

    assign enable      = i_MBINIT_REVERSALMB_end;
    assign counting    = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != TRAIN_ERROR);
    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next      = state_reg;
        repeat_next     = repeat_reg;
        done_rep_next   = 1'b0;
        func_lanes_next = o_Functional_Lanes;
        if (!enable) begin
            state_next  = IDLE;
            repeat_next = 1'b0;
        end else if (counting && timeout_hit) begin
            state_next = TRAIN_ERROR;
        end else begin
            case (state_reg)
                IDLE:              state_next = WAIT_BUSY_START;
                WAIT_BUSY_START:   if (!i_Busy_SideBand) state_next = SEND_START_REQ;
                SEND_START_REQ:    if (i_falling_edge_busy) state_next = WAIT_START_RESP;
                WAIT_START_RESP:
                    if (i_msg_valid && i_RX_SbMessage == MSG_START_RESP) state_next = DEGRADE_CHECK;
                DEGRADE_CHECK:
                    state_next = (i_lane_status == 2'b00) ? TRAIN_ERROR : WAIT_BUSY_DEGRADE;
                WAIT_BUSY_DEGRADE: if (!i_Busy_SideBand) state_next = SEND_DEGRADE_REQ;
                SEND_DEGRADE_REQ:
                    if (i_falling_edge_busy) begin
                        state_next    = WAIT_DEGRADE_RESP;
                        done_rep_next = repeat_reg;
                    end
                WAIT_DEGRADE_RESP: begin
                    // A response arriving together with a repeat request takes priority.
                    if (i_msg_valid && i_RX_SbMessage == MSG_DEG_RESP) begin
                        func_lanes_next = lanes_q;
                        state_next      = WAIT_BUSY_END;
                    end else if (i_Start_Repeater) begin
                        if (repeat_reg) begin
                            state_next = TRAIN_ERROR;
                        end else begin
                            repeat_next = 1'b1;
                            state_next  = DEGRADE_CHECK;
                        end
                    end
                end
                WAIT_BUSY_END:     if (!i_Busy_SideBand) state_next = SEND_END_REQ;
                SEND_END_REQ:      if (i_falling_edge_busy) state_next = WAIT_END_RESP;
                WAIT_END_RESP:
                    if (i_msg_valid && i_RX_SbMessage == MSG_END_RESP) state_next = DONE;
                DONE:              state_next = DONE;
                TRAIN_ERROR:       state_next = TRAIN_ERROR;
                default:           state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            repeat_reg <= 1'b0;
            lanes_q    <= 2'b11;
        end else begin
            state_reg  <= state_next;
            repeat_reg <= repeat_next;
            if (!enable || state_reg == IDLE) begin
                cnt_reg <= '0;
            end else if (counting) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (state_reg == DEGRADE_CHECK) begin
                lanes_q <= i_lane_status;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            o_TX_SbMessage        <= 4'b0000;
            o_ValidOutData        <= 1'b0;
            o_tx_msginfo          <= 2'b00;
            o_Done_Repeater       <= 1'b0;
            o_Functional_Lanes    <= 2'b11;
            o_train_error         <= 1'b0;
            o_MBINIT_REPAIRMB_end <= 1'b0;
        end else begin
            if (send_code(state_next) != 4'b0000 && state_next != state_reg) begin
                o_ValidOutData <= 1'b1;
                o_TX_SbMessage <= send_code(state_next);
            end else begin
                o_ValidOutData <= 1'b0;
                o_TX_SbMessage <= 4'b0000;
            end
            o_tx_msginfo          <= (state_next == SEND_DEGRADE_REQ) ? lanes_q : 2'b00;
            o_Done_Repeater       <= done_rep_next;
            o_Functional_Lanes    <= func_lanes_next;
            o_train_error         <= (state_next == TRAIN_ERROR);
            o_MBINIT_REPAIRMB_end <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_repairmb_initiator.sv
// Directed bench for repairmb_initiator: a hand-driven partner answers each request and
// every test task checks the initiator's outputs against hand-computed values.
module tb_repairmb_initiator;

    localparam int TO = 120;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_MBINIT_REVERSALMB_end = 1'b0;
    logic       i_Busy_SideBand = 1'b0;
    logic       i_falling_edge_busy = 1'b0;
    logic [3:0] i_RX_SbMessage = 4'b0000;
    logic       i_msg_valid = 1'b0;
    logic [1:0] i_lane_status = 2'b11;
    logic       i_Start_Repeater = 1'b0;
    logic [3:0] o_TX_SbMessage;
    logic       o_ValidOutData;
    logic [1:0] o_tx_msginfo;
    logic       o_Done_Repeater;
    logic [1:0] o_Functional_Lanes;
    logic       o_train_error;
    logic       o_MBINIT_REPAIRMB_end;

    int total = 0;
    int passed = 0;
    logic [3:0] cap_msg;
    logic [1:0] cap_info;
    bit ok;

    repairmb_initiator #(.TIMEOUT_CYCLES(TO), .CNT_W(7)) dut (
        .CLK(CLK),
        .rst_n(rst_n),
        .i_MBINIT_REVERSALMB_end(i_MBINIT_REVERSALMB_end),
        .i_Busy_SideBand(i_Busy_SideBand),
        .i_falling_edge_busy(i_falling_edge_busy),
        .i_RX_SbMessage(i_RX_SbMessage),
        .i_msg_valid(i_msg_valid),
        .i_lane_status(i_lane_status),
        .i_Start_Repeater(i_Start_Repeater),
        .o_TX_SbMessage(o_TX_SbMessage),
        .o_ValidOutData(o_ValidOutData),
        .o_tx_msginfo(o_tx_msginfo),
        .o_Done_Repeater(o_Done_Repeater),
        .o_Functional_Lanes(o_Functional_Lanes),
        .o_train_error(o_train_error),
        .o_MBINIT_REPAIRMB_end(o_MBINIT_REPAIRMB_end)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bounded wait for the next send strobe; captures the message and msginfo.
    task automatic wait_strobe(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (o_ValidOutData === 1'b1) begin
                found    = 1'b1;
                cap_msg  = o_TX_SbMessage;
                cap_info = o_tx_msginfo;
                break;
            end
        end
        if (!found) begin
            cap_msg  = 4'hx;
            cap_info = 2'bxx;
        end
    endtask

    task automatic fall_pulse();
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
    endtask

    task automatic send_msg(input logic [3:0] code);
        i_RX_SbMessage = code;
        i_msg_valid    = 1'b1;
        tick();
        i_msg_valid    = 1'b0;
        i_RX_SbMessage = 4'b0000;
    endtask

    // Partner answers three cycles after the sideband finishes the request.
    task automatic partner_reply(input logic [3:0] code);
        fall_pulse();
        tick();
        tick();
        send_msg(code);
    endtask

    task automatic disable_dut();
        i_MBINIT_REVERSALMB_end = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        total++; if (o_ValidOutData !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_ValidOutData); else passed++;
        total++; if (o_TX_SbMessage !== 4'b0000) $display("FAIL reset_msg: got %b expected 0000", o_TX_SbMessage); else passed++;
        total++; if (o_tx_msginfo !== 2'b00) $display("FAIL reset_msginfo: got %b expected 00", o_tx_msginfo); else passed++;
        total++; if (o_Functional_Lanes !== 2'b11) $display("FAIL reset_lanes: got %b expected 11", o_Functional_Lanes); else passed++;
        total++; if ({o_Done_Repeater, o_train_error, o_MBINIT_REPAIRMB_end} !== 3'b000)
            $display("FAIL reset_flags: got %b expected 000", {o_Done_Repeater, o_train_error, o_MBINIT_REPAIRMB_end}); else passed++;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        tick();
        total++; if (o_ValidOutData !== 1'b0) $display("FAIL idle_disabled_valid: got %b expected 0", o_ValidOutData); else passed++;
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        i_lane_status = 2'b11;
        i_MBINIT_REVERSALMB_end = 1'b1;
        wait_strobe(ok);
        total++; if (cap_msg !== 4'b0001) $display("FAIL nom_start_req: got %b expected 0001", cap_msg); else passed++;
        fall_pulse();
        total++; if (o_ValidOutData !== 1'b0) $display("FAIL nom_strobe_width: got %b expected 0", o_ValidOutData); else passed++;
        // A wrong message and an unqualified right one must both be ignored.
        send_msg(4'b0100);
        i_RX_SbMessage = 4'b0010; tick(); i_RX_SbMessage = 4'b0000;
        tick(); tick();
        total++; if (o_ValidOutData !== 1'b0) $display("FAIL nom_ignore: got valid %b expected 0", o_ValidOutData); else passed++;
        send_msg(4'b0010);
        wait_strobe(ok);
        total++; if ({cap_msg, cap_info} !== 6'b0101_11) $display("FAIL nom_degrade_req: got %b/%b expected 0101/11", cap_msg, cap_info); else passed++;
        partner_reply(4'b0110);
        wait_strobe(ok);
        total++; if ({cap_msg, cap_info} !== 6'b0011_00) $display("FAIL nom_end_req: got %b/%b expected 0011/00", cap_msg, cap_info); else passed++;
        partner_reply(4'b0100);
        total++; if (o_MBINIT_REPAIRMB_end !== 1'b1) $display("FAIL nom_done: got %b expected 1", o_MBINIT_REPAIRMB_end); else passed++;
        repeat (5) tick();
        total++; if ({o_MBINIT_REPAIRMB_end, o_train_error, o_Functional_Lanes} !== 4'b1011)
            $display("FAIL nom_done_held: got end/err/lanes %b expected 1011", {o_MBINIT_REPAIRMB_end, o_train_error, o_Functional_Lanes}); else passed++;
        disable_dut();
        total++; if (o_MBINIT_REPAIRMB_end !== 1'b0) $display("FAIL nom_disable_end: got %b expected 0", o_MBINIT_REPAIRMB_end); else passed++;
        $display("test_nominal done");
    endtask

    task automatic test_degrade();
        i_lane_status = 2'b01;
        i_MBINIT_REVERSALMB_end = 1'b1;
        wait_strobe(ok);
        partner_reply(4'b0010);
        wait_strobe(ok);
        total++; if ({cap_msg, cap_info} !== 6'b0101_01) $display("FAIL deg_req: got %b/%b expected 0101/01", cap_msg, cap_info); else passed++;
        fall_pulse();
        tick(); tick();
        // Response and repeat request together: the response wins.
        i_Start_Repeater = 1'b1;
        send_msg(4'b0110);
        i_Start_Repeater = 1'b0;
        total++; if (o_Functional_Lanes !== 2'b01) $display("FAIL deg_lanes: got %b expected 01", o_Functional_Lanes); else passed++;
        wait_strobe(ok);
        total++; if (cap_msg !== 4'b0011) $display("FAIL deg_resp_wins: got %b expected 0011", cap_msg); else passed++;
        partner_reply(4'b0100);
        total++; if (o_MBINIT_REPAIRMB_end !== 1'b1) $display("FAIL deg_done: got %b expected 1", o_MBINIT_REPAIRMB_end); else passed++;
        disable_dut();
        $display("test_degrade done");
    endtask

    task automatic test_repeat();
        i_lane_status = 2'b11;
        i_MBINIT_REVERSALMB_end = 1'b1;
        wait_strobe(ok);
        partner_reply(4'b0010);
        wait_strobe(ok);
        total++; if ({cap_msg, cap_info} !== 6'b0101_11) $display("FAIL rep_first_req: got %b/%b expected 0101/11", cap_msg, cap_info); else passed++;
        fall_pulse();
        total++; if (o_Done_Repeater !== 1'b0) $display("FAIL rep_no_pulse_first: got %b expected 0", o_Done_Repeater); else passed++;
        i_lane_status = 2'b10;
        i_Start_Repeater = 1'b1;
        tick();
        i_Start_Repeater = 1'b0;
        wait_strobe(ok);
        total++; if ({cap_msg, cap_info} !== 6'b0101_10) $display("FAIL rep_second_req: got %b/%b expected 0101/10", cap_msg, cap_info); else passed++;
        fall_pulse();
        total++; if (o_Done_Repeater !== 1'b1) $display("FAIL rep_done_pulse: got %b expected 1", o_Done_Repeater); else passed++;
        tick();
        total++; if (o_Done_Repeater !== 1'b0) $display("FAIL rep_done_width: got %b expected 0", o_Done_Repeater); else passed++;
        i_Start_Repeater = 1'b1;
        tick();
        i_Start_Repeater = 1'b0;
        total++; if (o_train_error !== 1'b1) $display("FAIL rep_second_repeat_err: got %b expected 1", o_train_error); else passed++;
        repeat (3) tick();
        total++; if ({o_train_error, o_MBINIT_REPAIRMB_end, o_Functional_Lanes} !== 4'b1001)
            $display("FAIL rep_err_held: got err/end/lanes %b expected 1001", {o_train_error, o_MBINIT_REPAIRMB_end, o_Functional_Lanes}); else passed++;
        disable_dut();
        total++; if (o_train_error !== 1'b0) $display("FAIL rep_disable_err: got %b expected 0", o_train_error); else passed++;
        $display("test_repeat done");
    endtask

    task automatic test_no_lanes();
        i_lane_status = 2'b00;
        i_MBINIT_REVERSALMB_end = 1'b1;
        wait_strobe(ok);
        partner_reply(4'b0010);
        tick();
        total++; if ({o_train_error, o_ValidOutData} !== 2'b10) $display("FAIL nolanes_err: got err/valid %b expected 10", {o_train_error, o_ValidOutData}); else passed++;
        disable_dut();
        $display("test_no_lanes done");
    endtask

    task automatic test_timeout();
        int n;
        i_lane_status = 2'b11;
        i_MBINIT_REVERSALMB_end = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 3 * TO; i++) begin
            tick();
            n++;
            i_falling_edge_busy = o_ValidOutData;
            if (o_train_error === 1'b1) break;
        end
        i_falling_edge_busy = 1'b0;
        total++; if (n !== TO) $display("FAIL timeout_cycles: got %0d expected %0d", n, TO); else passed++;
        disable_dut();
        $display("test_timeout done");
    endtask

    task automatic test_busy_enable();
        bit seen;
        i_lane_status = 2'b10;
        i_Busy_SideBand = 1'b1;
        i_MBINIT_REVERSALMB_end = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (o_ValidOutData !== 1'b0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL busy_hold: got strobe %b expected 0", seen); else passed++;
        i_Busy_SideBand = 1'b0;
        wait_strobe(ok);
        total++; if (cap_msg !== 4'b0001) $display("FAIL busy_release_req: got %b expected 0001", cap_msg); else passed++;
        partner_reply(4'b0010);
        wait_strobe(ok);
        partner_reply(4'b0110);
        wait_strobe(ok);
        fall_pulse();
        disable_dut();
        total++; if ({o_ValidOutData, o_TX_SbMessage, o_tx_msginfo, o_Done_Repeater, o_train_error, o_MBINIT_REPAIRMB_end} !== 10'b0)
            $display("FAIL drop_outputs: got %b expected 0", {o_ValidOutData, o_TX_SbMessage, o_tx_msginfo, o_Done_Repeater, o_train_error, o_MBINIT_REPAIRMB_end}); else passed++;
        total++; if (o_Functional_Lanes !== 2'b10) $display("FAIL drop_lanes_kept: got %b expected 10", o_Functional_Lanes); else passed++;
        i_MBINIT_REVERSALMB_end = 1'b1;
        wait_strobe(ok);
        total++; if (cap_msg !== 4'b0001) $display("FAIL reenable_req: got %b expected 0001", cap_msg); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({o_ValidOutData, o_Functional_Lanes} !== 3'b011)
            $display("FAIL async_reset: got valid/lanes %b expected 011", {o_ValidOutData, o_Functional_Lanes}); else passed++;
        $display("test_busy_enable done");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_degrade();
        test_repeat();
        test_no_lanes();
        test_timeout();
        test_busy_enable();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
        $fatal(1, "watchdog expired");
    end

endmodule
